// File: rtl/button_conditioner.sv
//============================================================================
// Module   : button_conditioner
// Purpose  : Front-panel button input stage. Synchronises raw active-low
//            push-to-ground pins to clk, debounces them on a prescaled tick
//            and produces clean active-high levels plus one-clk press pulses.
// Options  : Define BUTTON_AUTOREPEAT_EN to build per-button hold counters
//            that emit auto-repeat press pulses on REPEAT_MASK buttons.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module button_conditioner #(
  parameter int                   N_BUTTONS      = 6,
  parameter int                   TICK_DIV       = 256,
  parameter int                   DEBOUNCE_TICKS = 4,
  parameter int                   REPEAT_DELAY   = 5000,
  parameter int                   REPEAT_PERIOD  = 1000,
  parameter logic [N_BUTTONS-1:0] REPEAT_MASK    = 6'b111100
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_BUTTONS-1:0] buttons_n,
  output logic [N_BUTTONS-1:0] level,
  output logic [N_BUTTONS-1:0] press,
  output logic                 tick
);

  localparam int                  c_DIV_W    = $clog2(TICK_DIV);
  localparam int                  c_DB_W     = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [c_DIV_W-1:0]  c_DIV_LAST = c_DIV_W'(TICK_DIV - 1);
  localparam logic [c_DB_W-1:0]   c_DB_LAST  = c_DB_W'(DEBOUNCE_TICKS - 1);

`ifdef BUTTON_AUTOREPEAT_EN
  // Hold counter only ever needs to reach REPEAT_DELAY-1; after a repeat it is
  // reloaded so the next pulse lands REPEAT_PERIOD ticks later, never wrapping.
  localparam int                  c_HOLD_W      = $clog2(REPEAT_DELAY + 1);
  localparam logic [c_HOLD_W-1:0] c_HOLD_LAST   = c_HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [c_HOLD_W-1:0] c_HOLD_RELOAD = c_HOLD_W'(REPEAT_DELAY - REPEAT_PERIOD);
`endif

  // Reject parameter sets that would break the counter sizing above.
  if (TICK_DIV < 2 || DEBOUNCE_TICKS < 1 || REPEAT_DELAY < 1 ||
      REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY ||
      $bits(REPEAT_MASK) != N_BUTTONS) begin : g_bad_params
    $error("button_conditioner: illegal parameter set");
  end

  logic [c_DIV_W-1:0]   r_presc;
  logic                 w_tick;
  logic [N_BUTTONS-1:0] r_sync1;
  logic [N_BUTTONS-1:0] r_sync2;

  // Free-running prescaler; the clk where it sits at TICK_DIV-1 is the tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + c_DIV_W'(1);
    end
  end

  assign w_tick = (r_presc == c_DIV_LAST);
  assign tick   = w_tick;

  // Two-flop synchroniser on the inverted pins; reset value means "not pressed".
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= ~buttons_n;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_bit
    logic [c_DB_W-1:0] r_db_cnt;
    logic              r_level;
    logic              r_press;
    logic              w_flip;
    logic              w_rise;
    logic              w_rep;

    // A tick that would bring the disagreement run to DEBOUNCE_TICKS flips the level.
    assign w_flip = w_tick && (r_sync2[i] != r_level) && (r_db_cnt == c_DB_LAST);
    assign w_rise = w_flip && !r_level;

    // Debounce: any agreeing tick restarts the disagreement count.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_db_cnt <= '0;
        r_level  <= 1'b0;
      end else if (w_tick) begin
        if (r_sync2[i] == r_level) begin
          r_db_cnt <= '0;
        end else if (w_flip) begin
          r_level  <= r_sync2[i];
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + c_DB_W'(1);
        end
      end
    end

    // Press pulse registered alongside the level rise (or a repeat event).
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_press <= 1'b0;
      end else begin
        r_press <= w_rise || w_rep;
      end
    end

`ifdef BUTTON_AUTOREPEAT_EN
    if (REPEAT_MASK[i]) begin : g_rep
      logic [c_HOLD_W-1:0] r_hold;
      logic                w_fall;

      assign w_fall = w_flip && r_level;
      // The releasing tick never repeats, even if it lines up with the period.
      assign w_rep  = w_tick && r_level && !w_fall && (r_hold == c_HOLD_LAST);

      // Hold counter: cleared on either level edge, advances on held ticks.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_hold <= '0;
        end else if (w_rise || w_fall) begin
          r_hold <= '0;
        end else if (w_tick && r_level) begin
          if (r_hold == c_HOLD_LAST) begin
            r_hold <= c_HOLD_RELOAD;
          end else begin
            r_hold <= r_hold + c_HOLD_W'(1);
          end
        end
      end
    end else begin : g_norep
      assign w_rep = 1'b0;
    end
`else
    assign w_rep = 1'b0;
`endif

    assign level[i] = r_level;
    assign press[i] = r_press;
  end

endmodule

`default_nettype wire
